// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
//   Shared definitions for the RV32 pipeline hazard controller:
//   operand-forwarding select codes, ResultSrc encodings, the MDU
//   sequencer state type, and the forwarding-priority helper.
package pipeline_hazard_ctrl_pkg;

  // Operand select driven into the EX-stage ALU input muxes.
  localparam logic [1:0] FWD_RF = 2'b00;  // value read from the register file
  localparam logic [1:0] FWD_W  = 2'b01;  // result being written back in W
  localparam logic [1:0] FWD_M  = 2'b10;  // ALU result sitting in M

  // ResultSrc encodings used by the datapath's writeback mux.
  localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
  localparam logic [1:0] RESULTSRC_PC4  = 2'b10;

  // Multi-cycle MDU sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  // Select the freshest producer for one EX source register.
  // M is younger than W, so it takes priority. x0 is never forwarded
  // because writes to it are discarded by the register file.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// forward_unit
//   Combinational operand-forwarding logic for the two EX-stage sources.
//   Ports:
//     rs_e      in   2x5  EX source registers, index 0 = rs1, index 1 = rs2
//     rd_m      in   5    destination register in M
//     reg_wr_m  in   1    register-write enable in M
//     rd_w      in   5    destination register in W
//     reg_wr_w  in   1    register-write enable in W
//     fwd_sel   out  2x2  forwarding select per source (index as rs_e)
module forward_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [1:0][4:0] rs_e,
  input  logic [4:0]      rd_m,
  input  logic            reg_wr_m,
  input  logic [4:0]      rd_w,
  input  logic            reg_wr_w,
  output logic [1:0][1:0] fwd_sel
);

  // Both operands use the identical priority rule.
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign fwd_sel[gi] = fwd_select(rs_e[gi], rd_m, reg_wr_m, rd_w, reg_wr_w);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage RV32 pipeline.
//   Produces stall/flush controls for the IF/ID, ID/EX and EX/MEM
//   registers, EX operand forwarding selects, and sequences a multi-cycle
//   mul/div unit (MDU) in EX through a start/done handshake guarded by a
//   watchdog.
//   Ports:
//     clk, reset_n             clock, synchronous active-low reset
//     Rs1D, Rs2D               D-stage source registers
//     Rs1E, Rs2E, RdE          E-stage source/destination registers
//     RdM, RdW                 M/W destination registers
//     RegWriteM, RegWriteW     M/W register-write enables
//     ResultSrcE               result select of the E instruction
//     PCSrcE                   taken branch/jump resolved in E
//     MulDivE                  E instruction is an MDU op
//     mdu_done                 MDU result valid pulse
//     mdu_start                one-cycle MDU start pulse
//     StallF, StallD, StallE   hold PC, IF/ID, ID/EX
//     FlushD, FlushE, FlushM   clear IF/ID, ID/EX, EX/MEM
//     ForwardAE, ForwardBE     EX operand selects
//     mdu_err                  sticky watchdog-timeout flag
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int         MDU_TIMEOUT    = 40,
  parameter logic [1:0] LOAD_RESULTSRC = RESULTSRC_LOAD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MulDivE,
  input  logic       mdu_done,
  output logic       mdu_start,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       mdu_err
);

  // Wide enough to hold MDU_TIMEOUT itself, so the counter never wraps
  // before the watchdog fires.
  localparam int              CNT_W    = $clog2(MDU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  mdu_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  logic             timeout;
  logic             lw_stall;
  logic             mdu_hold;
  logic [1:0][1:0]  fwd_sel;

  // ---------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------
  forward_unit u_forward_unit (
    .rs_e     ({Rs2E, Rs1E}),
    .rd_m     (RdM),
    .reg_wr_m (RegWriteM),
    .rd_w     (RdW),
    .reg_wr_w (RegWriteW),
    .fwd_sel  (fwd_sel)
  );

  // Forwarding is forced to the register file while in reset so the
  // bubbles being injected carry no stale bypass selects.
  assign ForwardAE = reset_n ? fwd_sel[0] : FWD_RF;
  assign ForwardBE = reset_n ? fwd_sel[1] : FWD_RF;

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  // The load in E cannot supply its data until W, so a dependent
  // instruction in D must wait one cycle.
  assign lw_stall = reset_n
                 && (ResultSrcE == LOAD_RESULTSRC)
                 && (RdE != 5'd0)
                 && ((RdE == Rs1D) || (RdE == Rs2D));

  // Last permitted BUSY cycle: the watchdog releases the pipeline here.
  assign timeout = (state_reg == BUSY) && (cnt_reg == CNT_LAST);

  // EX is held from the start cycle until the release cycle. On release
  // (done or timeout) the hold drops in that same cycle so the op moves
  // to M on the following edge and is never seen in E by IDLE again.
  assign mdu_hold = reset_n
                 && (((state_reg == IDLE) && MulDivE)
                  || ((state_reg == BUSY) && !mdu_done && !timeout));

  // Only IDLE issues a start, so a held op is never restarted.
  assign mdu_start = reset_n && (state_reg == IDLE) && MulDivE;

  // ---------------------------------------------------------------------
  // Pipeline control outputs
  // ---------------------------------------------------------------------
  assign StallF = lw_stall || mdu_hold;
  assign StallD = lw_stall || mdu_hold;
  assign StallE = mdu_hold;
  // While EX is frozen, M must receive bubbles rather than duplicates.
  assign FlushM = mdu_hold;
  // A redirect or load bubble must not destroy an instruction still
  // held in E by the MDU; reset forces bubbles into D and E.
  assign FlushD = !reset_n || (PCSrcE && !mdu_hold);
  assign FlushE = !reset_n || ((lw_stall || PCSrcE) && !mdu_hold);

  assign mdu_err = err_reg;

  // ---------------------------------------------------------------------
  // MDU sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (MulDivE) begin
            state_reg <= BUSY;
            cnt_reg   <= '0;
          end
        end
        BUSY: begin
          if (mdu_done) begin
            // Done wins over a coinciding timeout.
            state_reg <= IDLE;
          end else if (timeout) begin
            state_reg <= IDLE;
            err_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl with a small watchdog limit.
//   A behavioural model (MDU op in flight + busy-cycle number + sticky
//   error) predicts every output each cycle; directed literal checks pin
//   the scenarios of interest.
module tb_pipeline_hazard_ctrl;

  localparam int T = 4;

  logic       clk;
  logic       reset_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MulDivE, mdu_done;
  logic       mdu_start, StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mdu_err;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(
    .MDU_TIMEOUT    (T),
    .LOAD_RESULTSRC (2'b01)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .MulDivE    (MulDivE),
    .mdu_done   (mdu_done),
    .mdu_start  (mdu_start),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .mdu_err    (mdu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  bit m_valid  = 1'b0;  // model synchronised after first edge
  bit m_active = 1'b0;  // an MDU op has been started and not released
  int m_busy_no = 0;    // 1-based number of the current waiting cycle
  bit m_err    = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_err    = 1'b0;
    end else if (m_active) begin
      if (mdu_done) begin
        m_active = 1'b0;
      end else if (m_busy_no == T) begin
        m_active = 1'b0;
        m_err    = 1'b1;
      end else begin
        m_busy_no++;
      end
    end else if (MulDivE) begin
      m_active  = 1'b1;
      m_busy_no = 1;
    end
    m_valid = 1'b1;
  end

  function automatic int model_fwd(input logic [4:0] rs);
    if (!reset_n) return 0;
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      bit hold, lw, start;
      start = reset_n && !m_active && MulDivE;
      if (!reset_n)      hold = 1'b0;
      else if (m_active) hold = !(mdu_done || m_busy_no == T);
      else               hold = MulDivE;
      lw = reset_n && ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      check("m_start",  int'(mdu_start), int'(start));
      check("m_stallF", int'(StallF), int'(lw || hold));
      check("m_stallD", int'(StallD), int'(lw || hold));
      check("m_stallE", int'(StallE), int'(hold));
      check("m_flushM", int'(FlushM), int'(hold));
      check("m_flushD", int'(FlushD), int'(!reset_n || (PCSrcE && !hold)));
      check("m_flushE", int'(FlushE), int'(!reset_n || ((lw || PCSrcE) && !hold)));
      check("m_fwdA",   int'(ForwardAE), model_fwd(Rs1E));
      check("m_fwdB",   int'(ForwardBE), model_fwd(Rs2E));
      check("m_err",    int'(mdu_err), int'(m_err));
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
    PCSrcE = 0; MulDivE = 0; mdu_done = 0;
  endtask

  task automatic settle(input string what);
    @(negedge clk);
    #1;
    $display("vec %-28s start=%0b stF=%0b stD=%0b stE=%0b flD=%0b flE=%0b flM=%0b fA=%0d fB=%0d err=%0b",
             what, mdu_start, StallF, StallD, StallE, FlushD, FlushE, FlushM,
             ForwardAE, ForwardBE, mdu_err);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    RegWriteM = 1; RdM = 5; Rs1E = 5;
    settle("reset");
    check("rst_fwdA", int'(ForwardAE), 0);
    check("rst_flushD", int'(FlushD), 1);
    check("rst_flushE", int'(FlushE), 1);
    check("rst_stallF", int'(StallF), 0);
    check("rst_start", int'(mdu_start), 0);
    advance(); advance();

    reset_n = 1'b1; clear_inputs();
    settle("out_of_reset");
    check("idle_flushD", int'(FlushD), 0);
    check("idle_err", int'(mdu_err), 0);
    advance();

    // Forwarding
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 7;
    settle("fwd_m_priority");
    check("fwdA_M", int'(ForwardAE), 2);
    check("fwdB_none", int'(ForwardBE), 0);
    advance();
    RdM = 0;
    settle("fwd_w_rdm_zero");
    check("fwdA_W", int'(ForwardAE), 1);
    advance();
    RdM = 5; Rs2E = 5; RegWriteM = 0;
    settle("fwdB_w");
    check("fwdB_W", int'(ForwardBE), 1);
    advance();
    clear_inputs();

    // Load-use
    ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
    settle("load_use");
    check("lu_stallF", int'(StallF), 1);
    check("lu_stallD", int'(StallD), 1);
    check("lu_flushE", int'(FlushE), 1);
    check("lu_stallE", int'(StallE), 0);
    advance();
    ResultSrcE = 2'b00; RdE = 0;
    settle("load_use_bubble");
    check("lu_done_stallF", int'(StallF), 0);
    check("lu_done_flushE", int'(FlushE), 0);
    advance();
    ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
    settle("load_rd_x0");
    check("lu_x0_stallF", int'(StallF), 0);
    advance();
    clear_inputs();

    // Branch
    PCSrcE = 1;
    settle("branch");
    check("br_flushD", int'(FlushD), 1);
    check("br_flushE", int'(FlushE), 1);
    check("br_stallF", int'(StallF), 0);
    advance();
    clear_inputs();

    // Stray done in IDLE
    mdu_done = 1;
    settle("done_in_idle");
    check("stray_stallE", int'(StallE), 0);
    advance();
    clear_inputs();

    // MDU handshake, done in second waiting cycle
    MulDivE = 1;
    settle("mdu_issue");
    check("hs_start", int'(mdu_start), 1);
    check("hs_stallE", int'(StallE), 1);
    check("hs_flushM", int'(FlushM), 1);
    advance();
    settle("mdu_wait");
    check("hs_nostart", int'(mdu_start), 0);
    check("hs_wait_stallF", int'(StallF), 1);
    advance();
    mdu_done = 1;
    settle("mdu_done");
    check("hs_rel_stallE", int'(StallE), 0);
    check("hs_rel_stallF", int'(StallF), 0);
    check("hs_rel_flushM", int'(FlushM), 0);
    check("hs_rel_start", int'(mdu_start), 0);
    advance();
    clear_inputs();
    settle("mdu_after");
    check("hs_after_start", int'(mdu_start), 0);
    advance();

    // Watchdog expiry
    MulDivE = 1;
    settle("wd_issue");
    for (int k = 1; k <= T; k++) begin
      advance();
      settle($sformatf("wd_busy_%0d", k));
      if (k < T) check("wd_held", int'(StallE), 1);
      else begin
        check("wd_release", int'(StallE), 0);
        check("wd_err_pending", int'(mdu_err), 0);
      end
    end
    advance();
    clear_inputs();
    settle("wd_err_set");
    check("wd_err", int'(mdu_err), 1);
    advance(); advance();
    settle("wd_err_sticky");
    check("wd_sticky", int'(mdu_err), 1);
    advance();

    reset_n = 1'b0;
    settle("reset_clear_err");
    check("rst2_flushE", int'(FlushE), 1);
    advance();
    reset_n = 1'b1;
    settle("err_cleared");
    check("rst2_err", int'(mdu_err), 0);
    advance();

    // Done coinciding with the last permitted cycle
    MulDivE = 1;
    settle("co_issue");
    for (int k = 1; k < T; k++) begin
      advance();
      settle($sformatf("co_busy_%0d", k));
    end
    advance();
    mdu_done = 1;
    settle("co_done_at_limit");
    check("co_release", int'(StallE), 0);
    advance();
    clear_inputs();
    settle("co_after");
    check("co_no_err", int'(mdu_err), 0);
    advance();

    // Reset in the middle of an op
    MulDivE = 1;
    settle("rm_issue");
    advance();
    settle("rm_busy");
    check("rm_busy_stallE", int'(StallE), 1);
    advance();
    reset_n = 1'b0;
    settle("rm_reset");
    check("rm_rst_stallE", int'(StallE), 0);
    check("rm_rst_start", int'(mdu_start), 0);
    advance();
    reset_n = 1'b1; MulDivE = 0;
    settle("rm_idle");
    check("rm_idle_stallE", int'(StallE), 0);
    check("rm_idle_err", int'(mdu_err), 0);
    advance();
    MulDivE = 1;
    settle("rm_fresh_issue");
    check("rm_fresh_start", int'(mdu_start), 1);
    advance();
    settle("rm_fresh_busy");
    check("rm_fresh_nostart", int'(mdu_start), 0);
    advance();
    mdu_done = 1;
    settle("rm_fresh_done");
    advance();
    clear_inputs();
    settle("end");
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
